// File: rtl/fsm_pkg.sv
// Shared definitions for the control FSM and its command sequencer.
// Holds FSM state codes, sequencer encoding and defaults.
package fsm_pkg;

    // Control FSM state codes, as seen on its 2-bit state output
    localparam logic [1:0] INIT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] BAD  = 2'd3;

    // Sequencer state encoding
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_OBSERVE = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int TIMEOUT_DEF = 16;
    localparam int HOLD_W_DEF  = 8;

    // Control lines driven into the FSM
    typedef struct packed {
        logic start;
        logic stop;
        logic mode;
    } ctl_t;

    // States in which an FSM transition is awaited under the watchdog
    function automatic logic wdog_active(input logic [2:0] s);
        return (s == S_ARM) || (s == S_OBSERVE) || (s == S_RELEASE);
    endfunction

endpackage

// File: rtl/fsm_seq_wdog.sv
// Transition watchdog: clearable up-counter with an expiry flag.
// Expiry fires on the TIMEOUT-th enabled cycle after a clear.
module fsm_seq_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == CW'(TIMEOUT - 1));

    // Count enabled cycles; hold at the limit, restart on clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fsm_seq.sv
// Command sequencer for the INIT/RUN/WAIT control FSM.
// Runs one host job per handshake and reports done or err.
module fsm_seq
    import fsm_pkg::*;
#(
    parameter int HOLD_W  = HOLD_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              start,
    output logic              stop,
    output logic              mode,
    input  logic [1:0]        state,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic [2:0]        seq_q;
    logic [2:0]        seq_n;
    ctl_t              ctl_q;
    ctl_t              ctl_n;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_n;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_n;
    logic              done_n;
    logic              err_n;
    logic              busy_n;
    logic              rdy_n;
    logic              abort;
    logic              accept;
    logic              wd_en;
    logic              wd_clr;
    logic              wd_exp;

    assign accept = cmd_valid && cmd_ready && (seq_q == S_IDLE);

    assign start = ctl_q.start;
    assign stop  = ctl_q.stop;
    assign mode  = ctl_q.mode;

    assign wd_en  = wdog_active(seq_q);
    assign wd_clr = !wd_en || (seq_n != seq_q);

    fsm_seq_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_exp)
    );

    // Next-state and next-output logic for the sequencer
    always_comb begin
        seq_n  = seq_q;
        ctl_n  = ctl_q;
        hold_n = hold_q;
        cnt_n  = cnt_q;
        done_n = 1'b0;
        err_n  = 1'b0;
        abort  = 1'b0;

        unique case (seq_q)
            S_IDLE: begin
                if (accept) begin
                    ctl_n.start = 1'b1;
                    ctl_n.stop  = ~cmd_mode;
                    ctl_n.mode  = cmd_mode;
                    hold_n      = cmd_hold;
                    seq_n       = S_ARM;
                end
            end
            S_ARM: begin
                if (state == RUN) begin
                    ctl_n.start = 1'b0;
                    seq_n       = S_OBSERVE;
                end else if (wd_exp) begin
                    abort = 1'b1;
                end
            end
            S_OBSERVE: begin
                if (ctl_q.mode && (state == INIT)) begin
                    seq_n = S_DONE;
                end else if (!ctl_q.mode && (state == WAIT)) begin
                    cnt_n = hold_q;
                    seq_n = S_HOLD;
                end else if (ctl_q.mode && (state == WAIT)) begin
                    abort = 1'b1;
                end else if (!ctl_q.mode && (state == INIT)) begin
                    abort = 1'b1;
                end else if (wd_exp) begin
                    abort = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    ctl_n.stop = 1'b0;
                    seq_n      = S_RELEASE;
                end else begin
                    cnt_n = cnt_q - HOLD_W'(1);
                end
            end
            S_RELEASE: begin
                if (state == INIT) begin
                    seq_n = S_DONE;
                end else if (wd_exp) begin
                    abort = 1'b1;
                end
            end
            S_DONE: begin
                done_n = 1'b1;
                seq_n  = S_IDLE;
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        // An illegal FSM code aborts any job in flight
        if ((seq_q != S_IDLE) && (state == BAD)) begin
            abort = 1'b1;
        end

        if (abort) begin
            err_n  = 1'b1;
            done_n = 1'b0;
            seq_n  = S_IDLE;
        end

        // Control lines are always released on return to IDLE
        if (seq_n == S_IDLE) begin
            ctl_n = '0;
        end

        busy_n = (seq_n != S_IDLE);
        rdy_n  = (seq_n == S_IDLE) && (state == INIT);
    end

    // Register sequencer state and every output
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_q     <= S_IDLE;
            ctl_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            seq_q     <= seq_n;
            ctl_q     <= ctl_n;
            hold_q    <= hold_n;
            cnt_q     <= cnt_n;
            cmd_ready <= rdy_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_fsm_seq.sv
// Testbench for fsm_seq with a behavioural control FSM attached.
// Table-driven normal jobs plus hand-written abort/reset cases.
module tb_fsm_seq;
    import fsm_pkg::*;

    localparam int NCAP = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_mode = 1'b0;
    logic [7:0] cmd_hold = 8'd0;
    logic       start;
    logic       stop;
    logic       mode;
    logic [1:0] state;
    logic       busy;
    logic       done;
    logic       err;

    fsm_seq #(
        .HOLD_W  (8),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_hold  (cmd_hold),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .state     (state),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural control FSM: reacts to its inputs on the next edge
    logic [1:0] fsm_q = INIT;
    logic       stuck = 1'b0;
    logic       ovr_en = 1'b0;
    logic [1:0] ovr_val = INIT;

    assign state = ovr_en ? ovr_val : fsm_q;

    always @(posedge clk) begin
        case (fsm_q)
            INIT:    if (start && !stuck) fsm_q <= RUN;
            RUN:     if (stop) fsm_q <= WAIT;
                     else if (mode) fsm_q <= INIT;
            WAIT:    if (!stop) fsm_q <= INIT;
            default: fsm_q <= INIT;
        endcase
    end

    int n_chk = 0;
    int n_fail = 0;

    logic       r_start [NCAP];
    logic       r_stop  [NCAP];
    logic       r_mode  [NCAP];
    logic       r_busy  [NCAP];
    logic       r_done  [NCAP];
    logic       r_err   [NCAP];
    logic       r_rdy   [NCAP];
    logic [1:0] r_st    [NCAP];

    int a_done_at;
    int a_err_at;
    int a_ndone;
    int a_nerr;
    int a_both;
    int a_start_last;
    int a_stop_last;
    int a_busy_fall;
    int a_wait;

    typedef struct {
        logic       m;
        logic [7:0] h;
        int         done_at;
        int         start_last;
        int         stop_last;
        int         wait_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", int'(cmd_ready), 1);
    endtask

    task automatic analyze();
        a_done_at = -1;
        a_err_at = -1;
        a_ndone = 0;
        a_nerr = 0;
        a_both = 0;
        a_start_last = -1;
        a_stop_last = -1;
        a_busy_fall = -1;
        a_wait = 0;
        for (int j = 0; j < NCAP; j++) begin
            if (r_done[j]) begin
                a_ndone++;
                if (a_done_at < 0) a_done_at = j;
            end
            if (r_err[j]) begin
                a_nerr++;
                if (a_err_at < 0) a_err_at = j;
            end
            if (r_done[j] && r_err[j]) a_both++;
            if (r_start[j]) a_start_last = j;
            if (r_stop[j]) a_stop_last = j;
            if (!r_busy[j] && a_busy_fall < 0) a_busy_fall = j;
            if (r_st[j] == WAIT) a_wait++;
        end
    endtask

    // Accept one job, then trace NCAP post-edge samples (j=0 is the accept edge)
    task automatic run_job(input logic m, input logic [7:0] h,
                           input int ovr_at, input logic [1:0] ov,
                           input int rst_at);
        wait_ready();
        cmd_mode = m;
        cmd_hold = h;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int j = 0; j < NCAP; j++) begin
            r_start[j] = start;
            r_stop[j]  = stop;
            r_mode[j]  = mode;
            r_busy[j]  = busy;
            r_done[j]  = done;
            r_err[j]   = err;
            r_rdy[j]   = cmd_ready;
            r_st[j]    = state;
            if (j == ovr_at) begin
                ovr_val = ov;
                ovr_en = 1'b1;
            end
            if (j == rst_at) reset = 1'b0;
            if (j == rst_at + 1) reset = 1'b1;
            tick();
        end
        ovr_en = 1'b0;
        analyze();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // {mode, hold, done_at, start_last, stop_last, wait_cycles}
        vecs[0] = '{1'b1, 8'd0,  4,  1, -1, 0};
        vecs[1] = '{1'b1, 8'd7,  4,  1, -1, 0};
        vecs[2] = '{1'b0, 8'd0,  7,  1,  3, 3};
        vecs[3] = '{1'b0, 8'd1,  8,  1,  4, 4};
        vecs[4] = '{1'b0, 8'd3,  10, 1,  6, 6};
        vecs[5] = '{1'b0, 8'd10, 17, 1, 13, 13};

        reset = 1'b0;
        repeat (3) tick();
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_stop", int'(stop), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b1;
        tick();
        chk("ready_after_rst", int'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].m, vecs[i].h, -1, INIT, -1);
            chk($sformatf("v%0d_done_at", i), a_done_at, vecs[i].done_at);
            chk($sformatf("v%0d_ndone", i), a_ndone, 1);
            chk($sformatf("v%0d_nerr", i), a_nerr, 0);
            chk($sformatf("v%0d_start_last", i), a_start_last,
                vecs[i].start_last);
            chk($sformatf("v%0d_stop_last", i), a_stop_last,
                vecs[i].stop_last);
            chk($sformatf("v%0d_busy_fall", i), a_busy_fall,
                vecs[i].done_at);
            chk($sformatf("v%0d_wait_cyc", i), a_wait, vecs[i].wait_cyc);
            chk($sformatf("v%0d_mode_held", i), int'(r_mode[0]),
                int'(vecs[i].m));
            chk($sformatf("v%0d_mode_clr", i),
                int'(r_mode[vecs[i].done_at]), 0);
        end

        // FSM ignores start: watchdog expires 16 cycles into ARM
        stuck = 1'b1;
        run_job(1'b1, 8'd0, -1, INIT, -1);
        stuck = 1'b0;
        chk("to_err_at", a_err_at, 16);
        chk("to_nerr", a_nerr, 1);
        chk("to_ndone", a_ndone, 0);
        chk("to_start_last", a_start_last, 15);
        chk("to_busy_fall", a_busy_fall, 16);
        chk("to_ready_back", int'(r_rdy[16]), 1);
        chk("to_mode_clr", int'(r_mode[16]), 0);

        // mode=1 job but the FSM lands in WAIT after RUN
        run_job(1'b1, 8'd0, 2, WAIT, -1);
        chk("wr_err_at", a_err_at, 3);
        chk("wr_ndone", a_ndone, 0);
        chk("wr_both", a_both, 0);
        chk("wr_start_clr", int'(r_start[3]), 0);

        // illegal code 3 while the sequencer sits in RELEASE
        run_job(1'b0, 8'd2, 6, BAD, -1);
        chk("il_stop_last", a_stop_last, 5);
        chk("il_err_at", a_err_at, 7);
        chk("il_ndone", a_ndone, 0);
        chk("il_busy_fall", a_busy_fall, 7);

        // reset pulse during HOLD abandons the job silently
        run_job(1'b0, 8'd10, -1, INIT, 5);
        chk("rh_start", int'(r_start[6]), 0);
        chk("rh_stop", int'(r_stop[6]), 0);
        chk("rh_mode", int'(r_mode[6]), 0);
        chk("rh_busy", int'(r_busy[6]), 0);
        chk("rh_ready", int'(r_rdy[6]), 0);
        chk("rh_ndone", a_ndone, 0);
        chk("rh_nerr", a_nerr, 0);
        chk("rh_busy_fall", a_busy_fall, 6);

        // next job after the reset completes normally
        run_job(1'b1, 8'd0, -1, INIT, -1);
        chk("post_done_at", a_done_at, 4);
        chk("post_nerr", a_nerr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
